ulpi_reg_ctrl: RTL and testbench

- ULPI link-side register and RXCMD engine, clocked by the 60 MHz PHY clock.
- Sits directly between the link init/control FSM and the USB3300-class ULPI pins (USB_DATA/DIR/NXT/STP).
- Serialises register write/read requests into ULPI TXCMD sequences, honours bus turnaround, and decodes RXCMD bytes.
- Used at power-up to program Function Control / OTG Control after PHY reset release.

---
 rtl/ulpi_reg_ctrl_if.sv | 29 ++
 rtl/ulpi_reg_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ulpi_reg_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_reg_ctrl_if.sv
// Signal bundle between the ULPI register engine, the PHY pads and the link control FSM.
// master: the register engine itself; slave: the surrounding pads/control logic.
interface ulpi_reg_ctrl_if;
  logic [7:0] ulpi_din;
  logic [7:0] ulpi_dout;
  logic       ulpi_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic       req;
  logic       we;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic       err;
  logic [7:0] rdata;
  logic       rxcmd_valid;
  logic [7:0] rxcmd;

  modport master (
    input  ulpi_din, ulpi_dir, ulpi_nxt, req, we, addr, wdata,
    output ulpi_dout, ulpi_oe, ulpi_stp, ack, err, rdata, rxcmd_valid, rxcmd
  );

  modport slave (
    output ulpi_din, ulpi_dir, ulpi_nxt, req, we, addr, wdata,
    input  ulpi_dout, ulpi_oe, ulpi_stp, ack, err, rdata, rxcmd_valid, rxcmd
  );
endinterface

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register access engine: serialises register writes/reads into TXCMD
// sequences with bus-turnaround handling, and captures RXCMD bytes from the PHY.
module ulpi_reg_ctrl #(
  parameter int unsigned NXT_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst_n,
  ulpi_reg_ctrl_if.master bus
);

  localparam int unsigned CntW = $clog2(NXT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StTxcmd,
    StWdata,
    StStp,
    StRdTurn,
    StRdData
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      txcmd_q, txcmd_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      rxcmd_q;
  logic            we_q, we_d;
  logic            abort_q, abort_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            dir_q;
  logic            rxcmd_valid_q;
  logic            dir_rise;
  logic            timeout;
  logic            rxcmd_cap;
  logic            link_owns_bus;

  assign dir_rise  = bus.ulpi_dir && !dir_q;
  assign timeout   = cnt_q == CntW'(NXT_TIMEOUT - 1);
  // Register read data also arrives with DIR=1/NXT=0; it must not be taken as an RXCMD.
  assign rxcmd_cap = bus.ulpi_dir && dir_q && !bus.ulpi_nxt && (state_q != StRdData);

  always_comb begin
    state_d = state_q;
    txcmd_d = txcmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    abort_d = abort_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ack_q blocks re-accepting the request that is still held during its own ACK
        if (bus.req && !bus.ulpi_dir && !dir_q && !ack_q) begin
          state_d = StTxcmd;
          txcmd_d = {1'b1, ~bus.we, bus.addr};
          wdata_d = bus.wdata;
          we_d    = bus.we;
          abort_d = 1'b0;
        end
      end
      StTxcmd: begin
        if (bus.ulpi_dir) begin
          state_d = StIdle;
        end else if (bus.ulpi_nxt) begin
          state_d = we_q ? StWdata : StRdTurn;
        end else if (timeout) begin
          state_d = StStp;
          abort_d = 1'b1;
        end
      end
      StWdata: begin
        if (bus.ulpi_dir) begin
          state_d = StIdle;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else if (bus.ulpi_nxt) begin
          state_d = StStp;
        end else if (timeout) begin
          state_d = StStp;
          abort_d = 1'b1;
        end
      end
      StStp: begin
        state_d = StIdle;
        ack_d   = 1'b1;
        err_d   = abort_q;
      end
      StRdTurn: begin
        if (dir_rise) begin
          state_d = StRdData;
        end else if (timeout) begin
          state_d = StIdle;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      StRdData: begin
        state_d = StIdle;
        rdata_d = bus.ulpi_din;
        ack_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {StTxcmd, StWdata, StRdTurn}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      txcmd_q       <= 8'h00;
      wdata_q       <= 8'h00;
      rdata_q       <= 8'h00;
      rxcmd_q       <= 8'h00;
      we_q          <= 1'b0;
      abort_q       <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      dir_q         <= 1'b0;
      rxcmd_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      txcmd_q       <= txcmd_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      we_q          <= we_d;
      abort_q       <= abort_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      dir_q         <= bus.ulpi_dir;
      rxcmd_valid_q <= rxcmd_cap;
      if (rxcmd_cap) begin
        rxcmd_q <= bus.ulpi_din;
      end
    end
  end

  // Output enable is gated combinationally by DIR so the link never fights the PHY.
  assign link_owns_bus = (state_q inside {StTxcmd, StWdata, StStp}) && !bus.ulpi_dir && !dir_q;

  always_comb begin
    bus.ulpi_dout = 8'h00;
    if (state_q == StTxcmd) begin
      bus.ulpi_dout = txcmd_q;
    end else if (state_q == StWdata) begin
      bus.ulpi_dout = wdata_q;
    end
  end

  assign bus.ulpi_oe     = link_owns_bus;
  assign bus.ulpi_stp    = state_q == StStp;
  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;
  assign bus.rxcmd_valid = rxcmd_valid_q;
  assign bus.rxcmd       = rxcmd_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Self-checking bench for ulpi_reg_ctrl: scripted PHY timelines and randomized traffic
// checked cycle by cycle against a protocol-level schedule model.
module tb_ulpi_reg_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // RXCMD reference: capture happens when DIR was already high last cycle and NXT is low.
  logic       m_dir_prev = 1'b0;
  logic       m_pend_valid = 1'b0;
  logic [7:0] m_rxcmd = 8'h00;

  ulpi_reg_ctrl_if bus ();

  ulpi_reg_ctrl #(
    .NXT_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = 6'h00;
    bus.wdata    = 8'h00;
    bus.ulpi_dir = 1'b0;
    bus.ulpi_nxt = 1'b0;
    bus.ulpi_din = 8'h00;
  endtask

  task automatic model_clear();
    m_dir_prev   = 1'b0;
    m_pend_valid = 1'b0;
    m_rxcmd      = 8'h00;
  endtask

  // One PHY-only cycle with no request pending.
  task automatic rx_step(input logic d, input logic n, input logic [7:0] v, output logic seen);
    logic cap;
    bus.req      = 1'b0;
    bus.ulpi_dir = d;
    bus.ulpi_nxt = n;
    bus.ulpi_din = v;
    @(negedge clk);
    tests++;
    if ({bus.ulpi_oe, bus.rxcmd_valid} !== {1'b0, m_pend_valid}) begin
      fails++;
      $display("FAIL rx_step oe/valid: got %b%b want 0%b", bus.ulpi_oe, bus.rxcmd_valid,
               m_pend_valid);
    end
    if (m_pend_valid) begin
      tests++;
      if (bus.rxcmd !== m_rxcmd) begin
        fails++;
        $display("FAIL rx_step rxcmd: got %h want %h", bus.rxcmd, m_rxcmd);
      end
    end
    seen = bus.rxcmd_valid;
    cap = d && m_dir_prev && !n;
    if (cap) m_rxcmd = v;
    m_pend_valid = cap;
    m_dir_prev   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #13;
    tests++;
    if ({bus.ulpi_dout, bus.ulpi_oe, bus.ulpi_stp, bus.ack, bus.err, bus.rdata,
         bus.rxcmd_valid, bus.rxcmd} !== 29'h0) begin
      fails++;
      $display("FAIL reset outputs: dout=%h oe=%b stp=%b ack=%b err=%b rdata=%h v=%b rx=%h want 0",
               bus.ulpi_dout, bus.ulpi_oe, bus.ulpi_stp, bus.ack, bus.err, bus.rdata,
               bus.rxcmd_valid, bus.rxcmd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_dir_hold();
    logic seen;
    for (int i = 0; i < 8; i++) rx_step(1'b1, 1'b0, 8'($urandom), seen);
    for (int i = 0; i < 3; i++) rx_step(1'b0, 1'b0, 8'($urandom), seen);
  endtask

  task automatic test_rxcmd();
    logic seen;
    int   pulses = 0;
    rx_step(1'b0, 1'b0, 8'h00, seen);
    rx_step(1'b1, 1'b0, 8'h40, seen);
    rx_step(1'b1, 1'b0, 8'h40, seen);
    for (int i = 0; i < 3; i++) begin
      rx_step(1'b0, 1'b0, 8'($urandom), seen);
      if (seen) pulses++;
    end
    tests++;
    if (pulses != 1 || bus.rxcmd !== 8'h40) begin
      fails++;
      $display("FAIL rxcmd_0x40: pulses=%0d rxcmd=%h want 1 pulse rxcmd=40", pulses, bus.rxcmd);
    end
  endtask

  task automatic test_rx_random();
    logic seen;
    logic d = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(2) == 0) d = ~d;
      rx_step(d, 1'($urandom), 8'($urandom), seen);
    end
    rx_step(1'b0, 1'b0, 8'h00, seen);
    rx_step(1'b0, 1'b0, 8'h00, seen);
  endtask

  // Register access against a cooperative PHY. tw: TXCMD cycles before NXT, dw: WDATA
  // cycles before NXT, dd: RD_TURN cycles before DIR rises. Cycle 0 = REQ first seen.
  task automatic do_xact(input logic we, input logic [5:0] addr, input logic [7:0] wd,
                         input int tw, input int dw, input int dd, input logic [7:0] rd);
    int          t, w, s, r, d, a;
    logic        e_oe, e_stp, e_ack;
    logic [7:0]  e_dout;
    logic [12:0] obs, expv;
    t = 1 + tw;
    if (we) begin
      w = t + 1 + dw;
      s = w + 1;
      a = s + 1;
      r = -10;
      d = -10;
    end else begin
      w = t;
      s = -10;
      r = t + 1 + dd;
      d = r + 1;
      a = d + 1;
    end
    for (int c = 0; c <= a + 1; c++) begin
      bus.req      = (c <= a);
      bus.we       = we;
      bus.addr     = addr;
      bus.wdata    = wd;
      bus.ulpi_nxt = (c == t) || (we && c == w);
      bus.ulpi_dir = !we && (c == r || c == d);
      bus.ulpi_din = (!we && c == d) ? rd : 8'($urandom);
      @(negedge clk);
      e_oe   = (c >= 1) && (we ? (c <= s) : (c <= t));
      e_dout = !e_oe ? 8'h00 : (c <= t) ? {1'b1, ~we, addr} : (c <= w) ? wd : 8'h00;
      e_stp  = we && (c == s);
      e_ack  = (c == a);
      obs  = {bus.ulpi_oe, bus.ulpi_oe ? bus.ulpi_dout : 8'h00, bus.ulpi_stp, bus.ack,
              bus.ack & bus.err, bus.rxcmd_valid};
      expv = {e_oe, e_dout, e_stp, e_ack, 1'b0, 1'b0};
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL xact we=%b addr=%h c=%0d {oe,dout,stp,ack,err,rxv}: got %h want %h",
                 we, addr, c, obs, expv);
      end
      if (!we && c == a) begin
        tests++;
        if (bus.rdata !== rd) begin
          fails++;
          $display("FAIL read_data addr=%h: got %h want %h", addr, bus.rdata, rd);
        end
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_xact(1'b1, 6'h04, 8'h45, 0, 0, 0, 8'h00);
  endtask

  task automatic test_read();
    do_xact(1'b0, 6'h0A, 8'h00, 0, 0, 1, 8'h06);
  endtask

  task automatic test_timeout();
    logic [12:0] obs, expv;
    logic        e_oe;
    for (int k = 0; k < 2; k++) begin
      // k=0: write with no NXT at all; k=1: read accepted but PHY never turns the bus
      for (int c = 0; c <= 19; c++) begin
        bus.req      = (c <= 18);
        bus.we       = (k == 0);
        bus.addr     = 6'h15;
        bus.wdata    = 8'hA5;
        bus.ulpi_nxt = (k == 1) && (c == 1);
        bus.ulpi_dir = 1'b0;
        @(negedge clk);
        e_oe = (k == 0) ? (c >= 1 && c <= 17) : (c == 1);
        obs  = {bus.ulpi_oe, bus.ulpi_oe ? bus.ulpi_dout : 8'h00, bus.ulpi_stp, bus.ack,
                bus.ack & bus.err, bus.rxcmd_valid};
        expv = {e_oe, (e_oe && c <= 16) ? ((k == 0) ? 8'h95 : 8'hD5) : 8'h00,
                (k == 0) && (c == 17), c == 18, c == 18, 1'b0};
        tests++;
        if (obs !== expv) begin
          fails++;
          $display("FAIL timeout k=%0d c=%0d {oe,dout,stp,ack,err,rxv}: got %h want %h",
                   k, c, obs, expv);
        end
        @(posedge clk);
        #1;
      end
      idle_inputs();
    end
  endtask

  task automatic test_dir_abort();
    logic [12:0] obs, expv;
    logic [7:0]  e_dout;
    for (int c = 0; c <= 10; c++) begin
      bus.req      = (c <= 9);
      bus.we       = 1'b1;
      bus.addr     = 6'h04;
      bus.wdata    = 8'h45;
      bus.ulpi_dir = (c == 2) || (c == 3);
      bus.ulpi_nxt = (c == 3) || (c == 6) || (c == 7);
      bus.ulpi_din = 8'($urandom);
      @(negedge clk);
      e_dout = (c == 1 || c == 6) ? 8'h84 : (c == 7) ? 8'h45 : 8'h00;
      obs  = {bus.ulpi_oe, bus.ulpi_oe ? bus.ulpi_dout : 8'h00, bus.ulpi_stp, bus.ack,
              bus.ack & bus.err, bus.rxcmd_valid};
      expv = {(c == 1) || (c >= 6 && c <= 8), e_dout, c == 8, c == 9, 1'b0, 1'b0};
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL dir_abort c=%0d {oe,dout,stp,ack,err,rxv}: got %h want %h", c, obs, expv);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      do_xact(1'($urandom), 6'($urandom), 8'($urandom), $urandom_range(4), $urandom_range(4),
              $urandom_range(3), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 6'h2B;
    bus.wdata = 8'h3C;
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({bus.ulpi_oe, bus.ulpi_dout} !== {1'b1, 8'hAB}) begin
      fails++;
      $display("FAIL reset_mid pre: oe=%b dout=%h want 1 ab", bus.ulpi_oe, bus.ulpi_dout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.ulpi_dout, bus.ulpi_oe, bus.ulpi_stp, bus.ack, bus.err, bus.rdata,
         bus.rxcmd_valid, bus.rxcmd} !== 29'h0) begin
      fails++;
      $display("FAIL reset_mid async: dout=%h oe=%b stp=%b ack=%b rdata=%h rx=%h want 0",
               bus.ulpi_dout, bus.ulpi_oe, bus.ulpi_stp, bus.ack, bus.rdata, bus.rxcmd);
    end
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({bus.ulpi_oe, bus.ulpi_stp, bus.ack} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid held: oe=%b stp=%b ack=%b want 000", bus.ulpi_oe, bus.ulpi_stp,
               bus.ack);
    end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    do_xact(1'b1, 6'h07, 8'h5A, 1, 0, 0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_dir_hold();
    test_rxcmd();
    test_write();
    test_read();
    test_timeout();
    test_dir_abort();
    test_rx_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
